async_sram_controller: RTL and testbench

ASYNC_SRAM_CONTROLLER -- requirements
Module: async_sram_controller

---
 rtl/sram_ctrl_pkg.sv | 14 +
 rtl/async_sram_controller.sv | 127 ++++++++++++
 tb/tb_async_sram_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      HOLD   = 2'd3
   } SramCtrlState_t;

   localparam int MAX_ACCESS_CYCLES = 15;
   localparam int CNT_W             = 4;

endpackage

// File: rtl/async_sram_controller.sv
// Single-port asynchronous SRAM controller: IDLE -> SETUP -> ACCESS(xN) -> HOLD -> IDLE.
// Address, data and both enables come straight from registers so the SRAM sees clean edges.
module async_sram_controller
   import sram_ctrl_pkg::*;
#(
   parameter int DEPTH         = 256,
   parameter int WIDTH         = 8,
   parameter int ADDR_BITS     = $clog2(DEPTH),
   parameter int ACCESS_CYCLES = 1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 ReqValid,
   output logic                 ReqReady,
   input  logic                 ReqWrite,
   input  logic [ADDR_BITS-1:0] ReqAddr,
   input  logic [WIDTH-1:0]     ReqWrData,
   output logic                 RspValid,
   output logic [WIDTH-1:0]     RspData,
   output logic [ADDR_BITS-1:0] SramAddr,
   output logic [WIDTH-1:0]     SramWrData,
   output logic                 SramRdEn,
   output logic                 SramWrEn,
   input  logic [WIDTH-1:0]     SramRdData,
   output logic                 Busy
);

   if ((ACCESS_CYCLES < 1) || (ACCESS_CYCLES > MAX_ACCESS_CYCLES)) begin : g_bad_access_cycles
      $error("async_sram_controller: ACCESS_CYCLES=%0d outside 1..%0d",
             ACCESS_CYCLES, MAX_ACCESS_CYCLES);
   end

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

   SramCtrlState_t        state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic                  write_q, write_d;
   logic                  rd_en_q, rd_en_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;

   // Next-state, request capture and look-ahead enable decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      write_d    = write_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (ReqValid) begin
               state_d = SETUP;
               addr_d  = ReqAddr;
               wdata_d = ReqWrData;
               write_d = ReqWrite;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = CNT_LOAD;
         end
         ACCESS: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = HOLD;
               if (!write_q) begin
                  rsp_data_d = SramRdData;
               end else begin
                  rsp_data_d = rsp_data_q;
               end
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Decoding from the next state lets the enables be plain flops aligned to ACCESS
      rd_en_d     = (state_d == ACCESS) && !write_d;
      wr_en_d     = (state_d == ACCESS) && write_d;
      rsp_valid_d = (state_d == HOLD);
   end

   // State and datapath registers
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         addr_q      <= {ADDR_BITS{1'b0}};
         wdata_q     <= {WIDTH{1'b0}};
         write_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         rd_en_q     <= rd_en_d;
         wr_en_q     <= wr_en_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign ReqReady   = (state_q == IDLE);
   assign Busy       = (state_q != IDLE);
   assign SramAddr   = addr_q;
   assign SramWrData = wdata_q;
   assign SramRdEn   = rd_en_q;
   assign SramWrEn   = wr_en_q;
   assign RspValid   = rsp_valid_q;
   assign RspData    = rsp_data_q;

endmodule

// File: tb/tb_async_sram_controller.sv
// Directed bench: DUT A (ACCESS_CYCLES=1) with a cycle reference model, DUT B (ACCESS_CYCLES=3).
module tb_async_sram_controller;

   localparam int AC_A = 1;
   localparam int AC_B = 3;

   logic Clk, Rst;
   int   n_asrt = 0;
   int   n_fail = 0;

   logic       va, wa, ReqReady_a, RspValid_a, SramRdEn_a, SramWrEn_a, Busy_a;
   logic [7:0] aa, da, RspData_a, SramAddr_a, SramWrData_a, SramRdData_a;
   logic       vb, wb, ReqReady_b, RspValid_b, SramRdEn_b, SramWrEn_b, Busy_b;
   logic [7:0] ab, db, RspData_b, SramAddr_b, SramWrData_b, SramRdData_b;

   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic [7:0] mem_ref [256];
   bit init_a = 1'b0, init_b = 1'b0, init_r = 1'b0;

   int         m_phase;
   logic [7:0] m_addr, m_wdata, m_rsp;
   logic       m_write;
   logic [7:0] rd_q [$];
   time        acc_t, prev_t;

   async_sram_controller #(.DEPTH(256), .WIDTH(8), .ADDR_BITS(8), .ACCESS_CYCLES(AC_A)) dut_a (
      .Clk(Clk), .Rst(Rst), .ReqValid(va), .ReqReady(ReqReady_a), .ReqWrite(wa),
      .ReqAddr(aa), .ReqWrData(da), .RspValid(RspValid_a), .RspData(RspData_a),
      .SramAddr(SramAddr_a), .SramWrData(SramWrData_a), .SramRdEn(SramRdEn_a),
      .SramWrEn(SramWrEn_a), .SramRdData(SramRdData_a), .Busy(Busy_a));

   async_sram_controller #(.DEPTH(256), .WIDTH(8), .ADDR_BITS(8), .ACCESS_CYCLES(AC_B)) dut_b (
      .Clk(Clk), .Rst(Rst), .ReqValid(vb), .ReqReady(ReqReady_b), .ReqWrite(wb),
      .ReqAddr(ab), .ReqWrData(db), .RspValid(RspValid_b), .RspData(RspData_b),
      .SramAddr(SramAddr_b), .SramWrData(SramWrData_b), .SramRdEn(SramRdEn_b),
      .SramWrEn(SramWrEn_b), .SramRdData(SramRdData_b), .Busy(Busy_b));

   function automatic logic [7:0] pat(input logic [7:0] a);
      return a ^ 8'h7C;
   endfunction

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // SRAM models: combinational read, write on the clock edge that ends an enabled cycle
   assign SramRdData_a = mem_a[SramAddr_a];
   assign SramRdData_b = mem_b[SramAddr_b];
   always @(posedge Clk) begin
      if (!init_a) begin
         for (int i = 0; i < 256; i++) mem_a[i] <= pat(8'(i));
         init_a <= 1'b1;
      end else if (SramWrEn_a) begin
         mem_a[SramAddr_a] <= SramWrData_a;
      end
   end
   always @(posedge Clk) begin
      if (!init_b) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= pat(8'(i));
         init_b <= 1'b1;
      end else if (SramWrEn_b) begin
         mem_b[SramAddr_b] <= SramWrData_b;
      end
   end

   // Reference model for DUT A: phase -1 idle, 0 setup, 1..AC access, AC+1 hold
   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         m_phase <= -1; m_addr <= 8'h00; m_wdata <= 8'h00; m_write <= 1'b0; m_rsp <= 8'h00;
         if (!init_r) begin
            for (int i = 0; i < 256; i++) mem_ref[i] <= pat(8'(i));
            init_r <= 1'b1;
         end
      end else if (m_phase < 0) begin
         if (va) begin
            m_phase <= 0; m_addr <= aa; m_wdata <= da; m_write <= wa;
         end
      end else begin
         if (m_phase == AC_A) begin
            if (m_write) mem_ref[m_addr] <= m_wdata;
            else         m_rsp <= mem_ref[m_addr];
         end
         m_phase <= (m_phase == AC_A + 1) ? -1 : m_phase + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Per-cycle comparison of DUT A against the model, plus enable exclusivity on both DUTs
   always @(negedge Clk) begin
      logic [31:0] ev, ov;
      ev = {3'b000, (m_phase < 0), (m_phase >= 0),
            (m_phase >= 1 && m_phase <= AC_A && !m_write),
            (m_phase >= 1 && m_phase <= AC_A && m_write),
            (m_phase == AC_A + 1), m_addr, m_wdata, m_rsp};
      ov = {3'b000, ReqReady_a, Busy_a, SramRdEn_a, SramWrEn_a, RspValid_a,
            SramAddr_a, SramWrData_a, RspData_a};
      chk("a_cycle", ov, ev);
      chk("a_excl", {31'd0, SramRdEn_a & SramWrEn_a}, 32'd0);
      chk("b_excl", {31'd0, SramRdEn_b & SramWrEn_b}, 32'd0);
      if (RspValid_a && !m_write) rd_q.push_back(RspData_a);
   end

   task automatic send_a(input logic w, input logic [7:0] a, input logic [7:0] d, input bit keep);
      @(negedge Clk);
      va = 1'b1; wa = w; aa = a; da = d;
      for (int i = 0; i < 20 && !ReqReady_a; i++) @(negedge Clk);
      chk("a_accept_wait", {31'd0, ReqReady_a}, 32'd1);
      @(posedge Clk);
      prev_t = acc_t;
      acc_t  = $time;
      if (!keep) begin
         #1 va = 1'b0;
      end
   endtask

   task automatic wait_rsp_a(input int exp_n);
      int got;
      got = -1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge Clk);
         if (RspValid_a) begin
            got = n;
            break;
         end
      end
      chk("a_rsp_latency", got, exp_n);
   endtask

   task automatic wait_idle_a();
      for (int i = 0; i < 20 && !ReqReady_a; i++) @(negedge Clk);
      chk("a_idle_wait", {31'd0, ReqReady_a}, 32'd1);
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_outs"}, {26'd0, SramRdEn_a, SramWrEn_a, RspValid_a, Busy_a, ReqReady_a, 1'b0},
          {26'd0, 5'b00001, 1'b0});
      chk({tag, "_data"}, {8'd0, SramAddr_a, SramWrData_a, RspData_a}, 32'd0);
   endtask

   initial begin
      int rd_cnt, qbase;
      va = 1'b0; wa = 1'b0; aa = 8'h00; da = 8'h00;
      vb = 1'b0; wb = 1'b0; ab = 8'h00; db = 8'h00;
      acc_t = 0; prev_t = 0;
      Rst = 1'b0;
      #1 Rst = 1'b1;
      #1;
      chk_reset_a("reset_a");
      chk("reset_b", {29'd0, ReqReady_b, Busy_b, RspValid_b}, 32'd4);
      @(negedge Clk); @(negedge Clk);
      Rst = 1'b0;

      // DUT B: read 0x40 (preloaded 0x3C) with three access cycles
      @(negedge Clk);
      chk("b_ready_pre", {31'd0, ReqReady_b}, 32'd1);
      vb = 1'b1; wb = 1'b0; ab = 8'h40;
      @(posedge Clk);
      #1 vb = 1'b0;
      rd_cnt = 0;
      for (int n = 1; n <= 7; n++) begin
         @(negedge Clk);
         chk("b_rden", {31'd0, SramRdEn_b}, {31'd0, (n >= 2 && n <= AC_B + 1)});
         chk("b_wren", {31'd0, SramWrEn_b}, 32'd0);
         chk("b_rspvalid", {31'd0, RspValid_b}, {31'd0, (n == AC_B + 2)});
         chk("b_ready", {31'd0, ReqReady_b}, {31'd0, (n >= AC_B + 3)});
         if (SramRdEn_b) rd_cnt++;
         if (n == AC_B + 2) chk("b_rspdata", {24'd0, RspData_b}, 32'h3C);
      end
      chk("b_rden_cycles", rd_cnt, AC_B);

      // DUT A: write 0xA5 to 0x12 then read it back
      send_a(1'b1, 8'h12, 8'hA5, 1'b0);
      wait_rsp_a(AC_A + 2);
      wait_idle_a();
      qbase = rd_q.size();
      send_a(1'b0, 8'h12, 8'h00, 1'b0);
      wait_rsp_a(AC_A + 2);
      wait_idle_a();
      chk("a_read_a5", {24'd0, rd_q[qbase]}, 32'hA5);

      // Back-to-back with ReqValid held high
      qbase = rd_q.size();
      send_a(1'b1, 8'h00, 8'h11, 1'b1);
      send_a(1'b1, 8'hFF, 8'h22, 1'b1);
      chk("b2b_gap1", 32'(acc_t - prev_t), 32'd40);
      send_a(1'b0, 8'h00, 8'h00, 1'b1);
      chk("b2b_gap2", 32'(acc_t - prev_t), 32'd40);
      send_a(1'b0, 8'hFF, 8'h00, 1'b0);
      chk("b2b_gap3", 32'(acc_t - prev_t), 32'd40);
      wait_rsp_a(AC_A + 2);
      wait_idle_a();
      chk("b2b_count", rd_q.size() - qbase, 2);
      chk("b2b_rd0", {24'd0, rd_q[qbase]}, 32'h11);
      chk("b2b_rd1", {24'd0, rd_q[qbase+1]}, 32'h22);

      // Reset during the ACCESS cycle of a write of 0x55 to 0x07
      send_a(1'b1, 8'h07, 8'h55, 1'b0);
      @(negedge Clk);
      @(posedge Clk);
      #2;
      chk("rst_mid_wren_before", {31'd0, SramWrEn_a}, 32'd1);
      Rst = 1'b1;
      #1;
      chk_reset_a("rst_mid");
      @(negedge Clk); @(negedge Clk);
      Rst = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge Clk);
         chk("rst_no_rsp", {31'd0, RspValid_a}, 32'd0);
      end
      qbase = rd_q.size();
      send_a(1'b0, 8'h07, 8'h00, 1'b0);
      wait_rsp_a(AC_A + 2);
      wait_idle_a();
      chk("rst_read_07", {24'd0, rd_q[qbase]}, {24'd0, pat(8'h07)});

      // Random traffic; the per-cycle model checks enables, address stability and read data
      for (int k = 0; k < 1000; k++) begin
         send_a(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      va = 1'b0;
      wait_idle_a();
      @(negedge Clk); @(negedge Clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
